// File: rtl/wb_sequencer_if.sv
// wb_sequencer_if: instruction handshake, ALU result and memory bus bundle for wb_sequencer.
interface wb_sequencer_if #(parameter int REG_AW = 4);
    logic              instr_valid;
    logic              instr_ready;
    logic [5:0]        instr;
    logic [REG_AW-1:0] dest;
    logic [31:0]       alu_c;
    logic              alu_addrch;
    logic [31:0]       alu_naddr;
    logic              alu_f3;
    logic [31:0]       store_data;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport slave (
        input  instr_valid, instr, dest, alu_c, alu_addrch, alu_naddr, alu_f3,
               store_data, mem_rdata, mem_ack,
        output instr_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output instr_valid, instr, dest, alu_c, alu_addrch, alu_naddr, alu_f3,
               store_data, mem_rdata, mem_ack,
        input  instr_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/wb_sequencer.sv
// wb_sequencer: retires one ALU result per instruction (register write, flags, PC, load/store).
module wb_sequencer #(
    parameter logic [31:0] PC_STEP = 32'd1,
    parameter int          REG_AW  = 4,
    parameter int          MEM_TMO = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    wb_sequencer_if.slave     bus,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic [31:0]       pc,
    output logic              f1,
    output logic              f2,
    output logic              mem_err,
    output logic              illegal
);
    localparam int CW = $clog2(MEM_TMO + 1);

    typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

    state_t            state, nxt;
    logic [REG_AW-1:0] dst_q;
    logic [CW-1:0]     cnt;
    logic              is_mem, enter, wr, brn, flg, ill, tmo;
    logic [31:0]       wd;

    assign bus.instr_ready = state == IDLE;
    assign is_mem = bus.instr[5:1] == 5'd3;

    // Architectural updates are registered on the edge entering WB, so they are visible during WB.
    always_comb begin
        nxt   = state;
        enter = 1'b0;
        wr    = 1'b0;
        wd    = bus.alu_c;
        brn   = 1'b0;
        flg   = 1'b0;
        ill   = 1'b0;
        tmo   = 1'b0;
        case (state)
            IDLE: if (bus.instr_valid) begin
                nxt   = is_mem ? MEM : WB;
                enter = !is_mem;
                wr    = bus.instr < 6'd6;
                brn   = bus.instr[5:1] == 5'd7 && bus.alu_addrch;
                flg   = bus.instr >= 6'd8 && bus.instr <= 6'd13;
                ill   = bus.instr[5:4] != 2'b00;
            end
            MEM: if (bus.mem_ack) begin
                nxt   = WB;
                enter = 1'b1;
                wr    = !bus.mem_we;
                wd    = bus.mem_rdata;
            end else if (cnt == CW'(MEM_TMO - 1)) begin
                nxt   = WB;
                enter = 1'b1;
                tmo   = 1'b1;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            pc            <= '0;
            f1            <= 1'b0;
            f2            <= 1'b0;
            rf_we         <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            mem_err       <= 1'b0;
            illegal       <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            dst_q         <= '0;
            cnt           <= '0;
        end else begin
            state   <= nxt;
            rf_we   <= wr;
            illegal <= illegal | ill;
            mem_err <= mem_err | tmo;
            if (wr) begin
                rf_waddr <= state == IDLE ? bus.dest : dst_q;
                rf_wdata <= wd;
            end
            if (enter)
                pc <= brn ? bus.alu_naddr : pc + PC_STEP;
            if (flg) begin
                f2 <= f1;
                f1 <= bus.alu_f3;
            end
            if (state == IDLE && nxt == MEM) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= ~bus.instr[0];
                bus.mem_addr  <= bus.alu_c;
                bus.mem_wdata <= bus.store_data;
                dst_q         <= bus.dest;
                cnt           <= '0;
            end else if (state == MEM) begin
                cnt <= cnt + 1'b1;
                if (nxt != MEM)
                    bus.mem_req <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: randomized scoreboard bench for wb_sequencer against an instruction-level model.
module tb_wb_sequencer;
    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata, pc;
    logic        f1, f2, mem_err, illegal;

    wb_sequencer_if #(.REG_AW(4)) bus();

    wb_sequencer #(.PC_STEP(32'd1), .REG_AW(4), .MEM_TMO(TMO)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc),
        .f1(f1), .f2(f2), .mem_err(mem_err), .illegal(illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          len;
        int          we;
        logic [3:0]  wa;
        logic [31:0] wd;
        int          req;
        logic        mwe;
        logic [31:0] ma, md, pc;
        logic        f1, f2, err, ill;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0, fails = 0;
    logic [31:0] m_pc = 0;
    logic m_f1 = 0, m_f2 = 0, m_err = 0, m_ill = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    // Monitor: gathers what happens while the DUT is busy, compares when instr_ready comes back.
    logic prev_rdy = 1'b1;
    int w_len = 0, w_we = 0, w_req = 0;
    logic [3:0] w_wa;
    logic [31:0] w_wd, w_ma, w_md;
    logic w_mwe;

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_rdy = 1'b1;
            w_len = 0; w_we = 0; w_req = 0;
        end else begin
            if (!bus.instr_ready) begin
                w_len++;
                if (rf_we) begin w_we++; w_wa = rf_waddr; w_wd = rf_wdata; end
                if (bus.mem_req) begin w_req++; w_mwe = bus.mem_we; w_ma = bus.mem_addr; w_md = bus.mem_wdata; end
            end else if (!prev_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("busy_cycles", w_len, e.len);
                    chk("rf_we_pulses", w_we, e.we);
                    if (e.we != 0) begin
                        chk("rf_waddr", {28'd0, w_wa}, {28'd0, e.wa});
                        chk("rf_wdata", w_wd, e.wd);
                    end
                    chk("mem_req_cycles", w_req, e.req);
                    if (e.req != 0) begin
                        chk("mem_we", {31'd0, w_mwe}, {31'd0, e.mwe});
                        chk("mem_addr", w_ma, e.ma);
                        chk("mem_wdata", w_md, e.md);
                    end
                    chk("pc", pc, e.pc);
                    chk("f1", {31'd0, f1}, {31'd0, e.f1});
                    chk("f2", {31'd0, f2}, {31'd0, e.f2});
                    chk("mem_err", {31'd0, mem_err}, {31'd0, e.err});
                    chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
                    chk("rf_we_idle", {31'd0, rf_we}, 32'd0);
                    chk("mem_req_idle", {31'd0, bus.mem_req}, 32'd0);
                end
                w_len = 0; w_we = 0; w_req = 0;
            end
            prev_rdy = bus.instr_ready;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.instr_ready && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) chk("ready_timeout", 0, 1);
    endtask

    // dly: cycle of MEM (1..TMO) in which mem_ack pulses; 0 means never acknowledged.
    task automatic issue(input logic [5:0] op, input logic [3:0] d, input logic [31:0] c,
                         input logic ac, input logic [31:0] na, input logic f3,
                         input logic [31:0] sd, input logic [31:0] rd, input int dly);
        exp_t e;
        logic mem, acked;
        mem   = op == 6'd6 || op == 6'd7;
        acked = mem && dly != 0;
        e.we  = (op < 6'd6 || (op == 6'd7 && acked)) ? 1 : 0;
        e.wa  = d;
        e.wd  = op == 6'd7 ? rd : c;
        e.req = mem ? (acked ? dly : TMO) : 0;
        e.len = mem ? e.req + 1 : 1;
        e.mwe = op == 6'd6;
        e.ma  = c;
        e.md  = sd;
        if (op >= 6'd8 && op <= 6'd13) begin m_f2 = m_f1; m_f1 = f3; end
        m_pc = ((op == 6'd14 || op == 6'd15) && ac) ? na : m_pc + 32'd1;
        if (mem && !acked) m_err = 1'b1;
        if (op >= 6'd16) m_ill = 1'b1;
        e.pc = m_pc; e.f1 = m_f1; e.f2 = m_f2; e.err = m_err; e.ill = m_ill;
        exp_q.push_back(e);
        @(negedge clock);
        bus.instr_valid = 1'b1; bus.instr = op; bus.dest = d; bus.alu_c = c;
        bus.alu_addrch = ac; bus.alu_naddr = na; bus.alu_f3 = f3;
        bus.store_data = sd; bus.mem_rdata = rd;
        wait_ready();
        @(posedge clock); #1;
        bus.instr_valid = 1'b0;
        if (acked) begin
            for (int k = 0; k < dly; k++) @(negedge clock);
            bus.mem_ack = 1'b1;
            @(posedge clock); #1;
            bus.mem_ack = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(negedge clock); n++; end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.instr_valid = 0; bus.instr = 0; bus.dest = 0; bus.alu_c = 0; bus.alu_addrch = 0;
        bus.alu_naddr = 0; bus.alu_f3 = 0; bus.store_data = 0; bus.mem_rdata = 0; bus.mem_ack = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_flags", {28'd0, f1, f2, mem_err, illegal}, 0);
        chk("rst_rf", {27'd0, rf_we, rf_waddr}, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_mem", {30'd0, bus.mem_req, bus.mem_we}, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_ready", {31'd0, bus.instr_ready}, 1);
        reset_n = 1'b1;

        issue(6'd0, 4'd3, 32'h12345678, 0, 0, 0, 0, 0, 0);
        issue(6'd8, 4'd1, 32'h0, 0, 0, 1, 0, 0, 0);
        issue(6'd9, 4'd1, 32'h0, 0, 0, 0, 0, 0, 0);
        issue(6'd15, 4'd0, 32'h0, 1, 32'h40, 0, 0, 0, 0);
        issue(6'd14, 4'd0, 32'h0, 1, 32'hFFFFFFFF, 0, 0, 0, 0);
        issue(6'd15, 4'd0, 32'h0, 0, 32'h55, 0, 0, 0, 0);
        issue(6'd7, 4'd5, 32'h100, 0, 0, 0, 0, 32'hCAFEBABE, 3);
        issue(6'd6, 4'd6, 32'h200, 0, 0, 0, 32'hDEADBEEF, 0, 2);
        issue(6'd7, 4'd9, 32'h300, 0, 0, 0, 0, 32'h0BADF00D, TMO);
        issue(6'd6, 4'd2, 32'h400, 0, 0, 0, 32'h11112222, 0, 0);
        wait_ready();
        @(negedge clock);
        bus.mem_ack = 1'b1;
        @(posedge clock); #1;
        bus.mem_ack = 1'b0;
        issue(6'd1, 4'd7, 32'hA5A5A5A5, 0, 0, 0, 0, 32'h77777777, 0);
        drain();

        @(negedge clock);
        bus.instr_valid = 1'b1; bus.instr = 6'd6; bus.alu_c = 32'h500;
        @(posedge clock); #1;
        bus.instr_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("abort_mem_req", {31'd0, bus.mem_req}, 0);
        chk("abort_pc", pc, 0);
        chk("abort_err", {31'd0, mem_err}, 0);
        chk("abort_ready", {31'd0, bus.instr_ready}, 1);
        @(posedge clock); #1;
        reset_n = 1'b1;
        m_pc = 0; m_f1 = 0; m_f2 = 0; m_err = 0; m_ill = 0;
        issue(6'd20, 4'd4, 32'h99, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(6, 7)) : 6'($urandom_range(0, 63));
            issue(op, 4'($urandom), $urandom, 1'($urandom), $urandom, 1'($urandom),
                  $urandom, $urandom, int'($urandom_range(0, TMO)));
        end
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
